// File: rtl/vsa_pkg.sv
// ----------------------------------------------------------------------------
// vsa_pkg
// Shared definitions for the parametrised VSA core: opcode and function-code
// encodings, the five-state sequencer enum, and helpers that derive the
// instruction-field widths from the register-file depth.
// Optional feature macro used by the core: VSA_BNEZ_EN.
// ----------------------------------------------------------------------------
package vsa_pkg;

    typedef enum logic [2:0] {
        OP_LW   = 3'd0,
        OP_SW   = 3'd1,
        OP_BEQZ = 3'd2,
        OP_ALU  = 3'd3,
        OP_ADDI = 3'd4,
        OP_SUBI = 3'd5,
        OP_BNEZ = 3'd6,
        OP_JR   = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        FN_ADD = 3'd0,
        FN_SUB = 3'd1,
        FN_AND = 3'd2,
        FN_OR  = 3'd3,
        FN_XOR = 3'd4,
        FN_NOT = 3'd5,
        FN_SRL = 3'd6,
        FN_SRA = 3'd7
    } fun_t;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    // Register-address field width for a register file of nreg entries.
    function automatic int rw_of(input int nreg);
        return $clog2(nreg);
    endfunction

    // Immediate field width: whatever is left of the I-format after
    // opcode and two register fields.
    function automatic int immw_of(input int rw);
        return rw + 3;
    endfunction

    // Full instruction width.
    function automatic int iw_of(input int rw);
        return 3 * rw + 6;
    endfunction

endpackage

// File: rtl/vsa_alu.sv
// ----------------------------------------------------------------------------
// vsa_alu
// Combinational execute unit of the VSA core. Produces the address for
// LW/SW, the immediate arithmetic for ADDI/SUBI and the register-register
// result for ALU-class instructions. Branch targets are formed in the core.
// Ports:
//   A, B     : register operands (DW bits)
//   imm      : I-format immediate, zero-extended here (IMMW bits)
//   opcode   : instruction opcode
//   fun      : R-format function code
//   result   : DW-bit result, modulo 2^DW
// ----------------------------------------------------------------------------
module vsa_alu
    import vsa_pkg::*;
#(
    parameter int DW   = 5,
    parameter int IMMW = 5
) (
    input  logic [DW-1:0]   A,
    input  logic [DW-1:0]   B,
    input  logic [IMMW-1:0] imm,
    input  opcode_t         opcode,
    input  fun_t            fun,
    output logic [DW-1:0]   result
);

    logic [DW-1:0]        imm_x;
    logic signed [DW-1:0] a_s;
    logic signed [DW-1:0] sra_s;

    assign imm_x = DW'(imm);
    assign a_s   = A;
    assign sra_s = a_s >>> 1;

    always_comb begin
        result = '0;
        case (opcode)
            OP_LW, OP_SW, OP_ADDI: result = A + imm_x;
            OP_SUBI:               result = A - imm_x;
            OP_ALU: begin
                case (fun)
                    FN_ADD:  result = A + B;
                    FN_SUB:  result = A - B;
                    FN_AND:  result = A & B;
                    FN_OR:   result = A | B;
                    FN_XOR:  result = A ^ B;
                    FN_NOT:  result = ~A;
                    FN_SRL:  result = A >> 1;
                    FN_SRA:  result = sra_s;
                    default: result = '0;
                endcase
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/vsa_param_core.sv
// ----------------------------------------------------------------------------
// vsa_param_core
// Five-state (IF, ID, EX, MEM, WB) non-pipelined VSA processor, generalised
// in data width, PC width and register-file depth, with ready/valid stalls
// on both memory ports and an asynchronous active-high reset.
// Optional feature macro: VSA_BNEZ_EN (opcode 6 = BNEZ, opcode 7 = JR);
// without it opcodes 6 and 7 are NOPs that only advance the PC by 2.
// Ports:
//   clock, reset  : rising-edge clock, async active-high reset
//   PC            : instruction address
//   imem_req      : fetch request, high only in IF
//   imem_ready    : instruction valid this cycle
//   instruction   : fetched instruction word
//   ALUOutput     : data address / ALU result register
//   mem_req       : data access request, high in MEM for LW/SW
//   mem_ready     : data access completes this cycle
//   datain        : load data
//   dataout       : store data (register B)
//   wr            : store strobe (mem_req and opcode SW)
// ----------------------------------------------------------------------------
module vsa_param_core
    import vsa_pkg::*;
#(
    parameter  int DW   = 5,
    parameter  int PCW  = 5,
    parameter  int NREG = 4,
    localparam int RW   = rw_of(NREG),
    localparam int IMMW = immw_of(RW),
    localparam int IW   = iw_of(RW)
) (
    input  logic           clock,
    input  logic           reset,
    output logic [PCW-1:0] PC,
    output logic           imem_req,
    input  logic           imem_ready,
    input  logic [IW-1:0]  instruction,
    output logic [DW-1:0]  ALUOutput,
    output logic           mem_req,
    input  logic           mem_ready,
    input  logic [DW-1:0]  datain,
    output logic [DW-1:0]  dataout,
    output logic           wr
);

    state_t          state_q;
    logic [PCW-1:0]  pc_q, npc_q, pc_d;
    logic [IW-1:0]   ir_q;
    logic [DW-1:0]   a_q, b_q, alu_q, lmd_q;
    logic            cond_q;
    logic [DW-1:0]   regs_q [NREG];
    logic            imem_req_q, mem_req_q, wr_q;

    // Instruction fields. The I-format destination shares the R-format s2 slot.
    opcode_t         op;
    fun_t            fun;
    logic [RW-1:0]   s1, s2, d_r, d_i;
    logic [IMMW-1:0] imm;

    assign op  = opcode_t'(ir_q[IW-1 -: 3]);
    assign s1  = ir_q[IW-4 -: RW];
    assign s2  = ir_q[IW-4-RW -: RW];
    assign d_i = s2;
    assign d_r = ir_q[IW-4-2*RW -: RW];
    assign fun = fun_t'(ir_q[2:0]);
    assign imm = ir_q[IMMW-1:0];

    logic is_mem, is_branch, is_arith;
    assign is_mem   = (op == OP_LW) || (op == OP_SW);
    assign is_arith = (op inside {OP_LW, OP_SW, OP_ADDI, OP_SUBI, OP_ALU});
`ifdef VSA_BNEZ_EN
    assign is_branch = (op == OP_BEQZ) || (op == OP_BNEZ);
`else
    assign is_branch = (op == OP_BEQZ);
`endif

    logic [DW-1:0] alu_res;

    vsa_alu #(
        .DW   (DW),
        .IMMW (IMMW)
    ) u_alu (
        .A      (a_q),
        .B      (b_q),
        .imm    (imm),
        .opcode (op),
        .fun    (fun),
        .result (alu_res)
    );

    // Branch offset is the low IMMW-1 immediate bits shifted left once, so
    // the target stays even whenever NPC is even.
    logic [PCW-1:0] br_tgt;
    assign br_tgt = npc_q + PCW'({imm[IMMW-2:0], 1'b0});

`ifdef VSA_BNEZ_EN
    logic [PCW-1:0] a_pc;
    assign a_pc = PCW'(a_q);
`endif

    always_comb begin
        pc_d = npc_q;
        if (is_branch && cond_q) pc_d = PCW'(alu_q);
`ifdef VSA_BNEZ_EN
        if (op == OP_JR) pc_d = {a_pc[PCW-1:1], 1'b0};
`endif
    end

    // Write-back selection; R0 writes are dropped at the register update.
    logic          wb_en;
    logic [RW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    assign wb_en   = (op inside {OP_ALU, OP_ADDI, OP_SUBI, OP_LW});
    assign wb_addr = (op == OP_ALU) ? d_r : d_i;
    assign wb_data = (op == OP_LW) ? lmd_q : alu_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IF;
            pc_q       <= '0;
            npc_q      <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            alu_q      <= '0;
            lmd_q      <= '0;
            cond_q     <= 1'b0;
            imem_req_q <= 1'b1;
            mem_req_q  <= 1'b0;
            wr_q       <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                S_IF: begin
                    if (imem_ready) begin
                        ir_q       <= instruction;
                        npc_q      <= pc_q + PCW'(2);
                        imem_req_q <= 1'b0;
                        state_q    <= S_ID;
                    end
                end
                S_ID: begin
                    a_q     <= regs_q[s1];
                    b_q     <= regs_q[s2];
                    state_q <= S_EX;
                end
                S_EX: begin
                    if (is_branch) begin
                        alu_q  <= DW'(br_tgt);
                        cond_q <= (op == OP_BEQZ) ? (a_q == '0) : (a_q != '0);
                    end else if (is_arith) begin
                        alu_q <= alu_res;
                    end
                    mem_req_q <= is_mem;
                    wr_q      <= (op == OP_SW);
                    state_q   <= S_MEM;
                end
                S_MEM: begin
                    // Non-memory instructions pass straight through.
                    if (!mem_req_q || mem_ready) begin
                        if (op == OP_LW) lmd_q <= datain;
                        pc_q      <= pc_d;
                        mem_req_q <= 1'b0;
                        wr_q      <= 1'b0;
                        state_q   <= S_WB;
                    end
                end
                S_WB: begin
                    if (wb_en && (wb_addr != '0)) regs_q[wb_addr] <= wb_data;
                    imem_req_q <= 1'b1;
                    state_q    <= S_IF;
                end
                default: begin
                    imem_req_q <= 1'b1;
                    mem_req_q  <= 1'b0;
                    wr_q       <= 1'b0;
                    state_q    <= S_IF;
                end
            endcase
        end
    end

    assign PC        = pc_q;
    assign imem_req  = imem_req_q;
    assign ALUOutput = alu_q;
    assign mem_req   = mem_req_q;
    assign dataout   = b_q;
    assign wr        = wr_q;

    a_pc_even: assert property (@(posedge clock) disable iff (reset)
        (pc_q[0] == 1'b0) && (npc_q[0] == 1'b0));
    a_r0_zero: assert property (@(posedge clock) disable iff (reset)
        regs_q[0] == '0);
    a_req_excl: assert property (@(posedge clock) disable iff (reset)
        !(imem_req_q && mem_req_q));

endmodule

// File: tb/tb_vsa_param_core.sv
module tb_vsa_param_core;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  PC;
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic [11:0] instruction = '0;
    logic [4:0]  ALUOutput;
    logic        mem_req;
    logic        mem_ready = 1'b0;
    logic [4:0]  datain = '0;
    logic [4:0]  dataout;
    logic        wr;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [4:0] fetch_q[$];
    logic [4:0] ld_addr_q[$];
    logic [4:0] st_addr_q[$];
    logic [4:0] st_data_q[$];

    vsa_param_core #(.DW(5), .PCW(5), .NREG(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .PC          (PC),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .instruction (instruction),
        .ALUOutput   (ALUOutput),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .datain      (datain),
        .dataout     (dataout),
        .wr          (wr)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] enc_i(input logic [2:0] op, input logic [1:0] s1,
                                          input logic [1:0] d, input logic [4:0] imm);
        return {op, s1, d, imm};
    endfunction

    function automatic logic [11:0] enc_r(input logic [1:0] s1, input logic [1:0] s2,
                                          input logic [1:0] d, input logic [2:0] fn);
        return {3'd3, s1, s2, d, fn};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard side: compare handshakes against queued expectations.
    always @(negedge clock) begin
        if (!reset) begin
            if (imem_req && mem_req) chk("req_exclusive", 1, 0);
            if (imem_req && imem_ready) begin
                if (fetch_q.size() == 0) chk("fetch_unexpected", 1, 0);
                else chk("fetch_pc", PC, fetch_q.pop_front());
            end
            if (mem_req && mem_ready) begin
                if (wr) begin
                    if (st_addr_q.size() == 0) chk("store_unexpected", 1, 0);
                    else begin
                        chk("store_addr", ALUOutput, st_addr_q.pop_front());
                        chk("store_data", dataout, st_data_q.pop_front());
                    end
                end else begin
                    if (ld_addr_q.size() == 0) chk("load_unexpected", 1, 0);
                    else chk("load_addr", ALUOutput, ld_addr_q.pop_front());
                end
            end
        end
    end

    // Fetch one instruction and serve memory until the core is back in IF.
    task automatic run_instr(input logic [11:0] ins, input logic [4:0] pc,
                             input int istall, input int mstall, input logic [4:0] din,
                             output int mcyc, output int wcyc);
        int guard;
        mcyc = 0;
        wcyc = 0;
        fetch_q.push_back(pc);
        guard = 0;
        while (!imem_req && guard < 20) begin step(); guard++; end
        if (!imem_req) begin chk("fetch_timeout", 0, 1); return; end
        repeat (istall) step();
        imem_ready = 1'b1;
        instruction = ins;
        step();
        imem_ready = 1'b0;
        guard = 0;
        while (!imem_req && guard < 40) begin
            mem_ready = 1'b0;
            if (mem_req) begin
                mcyc++;
                if (wr) wcyc++;
                if (mcyc > mstall) begin
                    mem_ready = 1'b1;
                    datain = din;
                end
            end
            step();
            guard++;
        end
        mem_ready = 1'b0;
        if (!imem_req) chk("complete_timeout", 0, 1);
    endtask

    initial begin
        int mc, wc, guard;

        // Reset state
        repeat (2) step();
        chk("rst_pc", PC, 0);
        chk("rst_alu", ALUOutput, 0);
        chk("rst_dataout", dataout, 0);
        chk("rst_imem_req", imem_req, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wr", wr, 0);
        reset = 1'b0;

        // ADDI R1,R0,#5 with a stalled fetch
        run_instr(enc_i(3'd4, 2'd0, 2'd1, 5'd5), 5'd0, 2, 0, 5'd0, mc, wc);
        chk("addi_alu", ALUOutput, 5);
        chk("addi_no_mem", mc, 0);

        // LW R2,0(R1) with 3 stall cycles, load data 9
        ld_addr_q.push_back(5'd5);
        run_instr(enc_i(3'd0, 2'd1, 2'd2, 5'd0), 5'd2, 0, 3, 5'd9, mc, wc);
        chk("lw_mem_cycles", mc, 4);
        chk("lw_wr_cycles", wc, 0);

        // BEQZ R0,#3 at PC=4: taken to 6+6=12
        run_instr(enc_i(3'd2, 2'd0, 2'd0, 5'd3), 5'd4, 0, 0, 5'd0, mc, wc);
        chk("beqz_taken_tgt", ALUOutput, 12);

        // SW R2,1(R1): address 6, data 9, one strobe cycle
        st_addr_q.push_back(5'd6); st_data_q.push_back(5'd9);
        run_instr(enc_i(3'd1, 2'd1, 2'd2, 5'd1), 5'd12, 0, 0, 5'd0, mc, wc);
        chk("sw_wr_cycles", wc, 1);
        chk("sw_mem_cycles", mc, 1);

        // BEQZ R1(=5),#3 at 14: target 22 computed but not taken
        run_instr(enc_i(3'd2, 2'd1, 2'd0, 5'd3), 5'd14, 0, 0, 5'd0, mc, wc);
        chk("beqz_nt_tgt", ALUOutput, 22);

        // SUB R3 = R0 - R1 = -5 mod 32 = 27
        run_instr(enc_r(2'd0, 2'd1, 2'd3, 3'd1), 5'd16, 0, 0, 5'd0, mc, wc);
        chk("sub_wrap", ALUOutput, 27);

        // SW R3,0(R0): address 0, data 27
        st_addr_q.push_back(5'd0); st_data_q.push_back(5'd27);
        run_instr(enc_i(3'd1, 2'd0, 2'd3, 5'd0), 5'd18, 0, 0, 5'd0, mc, wc);

        // ADD R0 = R1 + R2 = 14, write dropped
        run_instr(enc_r(2'd1, 2'd2, 2'd0, 3'd0), 5'd20, 0, 0, 5'd0, mc, wc);
        chk("add_r0_alu", ALUOutput, 14);

        // SW R0,0(R1): address 5, data must still be 0
        st_addr_q.push_back(5'd5); st_data_q.push_back(5'd0);
        run_instr(enc_i(3'd1, 2'd1, 2'd0, 5'd0), 5'd22, 0, 0, 5'd0, mc, wc);

        // XOR R3 = 5 ^ 9 = 12
        run_instr(enc_r(2'd1, 2'd2, 2'd3, 3'd4), 5'd24, 0, 0, 5'd0, mc, wc);
        chk("xor_alu", ALUOutput, 12);

        // SUBI R3,R0,#4 = 28
        run_instr(enc_i(3'd5, 2'd0, 2'd3, 5'd4), 5'd26, 0, 0, 5'd0, mc, wc);
        chk("subi_alu", ALUOutput, 28);

        // SRA R3: 11100 -> 11110 = 30
        run_instr(enc_r(2'd3, 2'd0, 2'd3, 3'd7), 5'd28, 0, 0, 5'd0, mc, wc);
        chk("sra_alu", ALUOutput, 30);

        // Opcode 6 NOP at 30: ALUOutput unchanged, PC wraps to 0
        run_instr(enc_i(3'd6, 2'd1, 2'd1, 5'd7), 5'd30, 0, 0, 5'd0, mc, wc);
        chk("nop_alu_kept", ALUOutput, 30);
        chk("nop_no_mem", mc, 0);

        // SW R2,0(R1) stalled in MEM, then reset mid-access (not retried)
        fetch_q.push_back(5'd0);
        imem_ready = 1'b1;
        instruction = enc_i(3'd1, 2'd1, 2'd2, 5'd0);
        step();
        imem_ready = 1'b0;
        guard = 0;
        while (!mem_req && guard < 10) begin step(); guard++; end
        chk("abort_mem_req", mem_req, 1);
        step();
        step();
        chk("abort_wr_stalled", wr, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_wr", wr, 0);
        chk("abort_mem_req_low", mem_req, 0);
        chk("abort_imem_req", imem_req, 1);
        chk("abort_pc", PC, 0);
        chk("abort_alu", ALUOutput, 0);
        chk("abort_dataout", dataout, 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Registers cleared: stores of R1 and R3 carry 0
        st_addr_q.push_back(5'd0); st_data_q.push_back(5'd0);
        run_instr(enc_i(3'd1, 2'd2, 2'd1, 5'd0), 5'd0, 0, 0, 5'd0, mc, wc);
        st_addr_q.push_back(5'd3); st_data_q.push_back(5'd0);
        run_instr(enc_i(3'd1, 2'd0, 2'd3, 5'd3), 5'd2, 0, 1, 5'd0, mc, wc);
        chk("sw_stall_wr_cycles", wc, 2);

        // SUBI R1,R0,#1 = 31
        run_instr(enc_i(3'd5, 2'd0, 2'd1, 5'd1), 5'd4, 0, 0, 5'd0, mc, wc);
        chk("subi_wrap", ALUOutput, 31);

        repeat (2) step();
        chk("fetch_q_empty", fetch_q.size(), 0);
        chk("load_q_empty", ld_addr_q.size(), 0);
        chk("store_q_empty", st_addr_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
